// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the FSM state encoding, the queued request record and the
// address error predicate used by the top level.
package dmem_pkg;

  localparam int WORDS_LOG2_DEF = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // 69-bit request record as held in the queue.
  typedef struct packed {
    logic        store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  // Address falls outside the word array or is not word aligned.
  function automatic logic addr_err(input logic [31:0] addr, input int words_log2);
    return ((addr >> (words_log2 + 2)) != 32'd0) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_req_fifo.sv
// In-order request queue for dmem_responder.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (pointers/count only)
//   i_push, i_data  enqueue request; ignored while full
//   i_pop           dequeue head; ignored while empty
//   o_data          current head record
//   o_full, o_empty, o_count  occupancy status
module dmem_req_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  req_t                       i_data,
  input  logic                       i_pop,
  output req_t                       o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  req_t          r_mem [DEPTH];
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A pop never frees a slot for a push on the same edge when full.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for execute-stage loads and stores.
// Requests are queued in order, executed one at a time against a
// 2**WORDS_LOG2 x 32 word array with byte write enables, and each one
// produces exactly one response.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_store, req_addr, req_wdata, req_be   request payload
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata, rsp_err, rsp_store            response payload
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int WORDS_LOG2 = WORDS_LOG2_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_store
);

  logic [1:0]            r_state;
  logic                  r_rsp_err;
  logic                  r_rsp_store;
  logic                  r_rsp_rd_ok;
  logic [31:0]           r_ram_q;
  logic [31:0]           r_mem [2**WORDS_LOG2];

  logic                  w_full;
  logic                  w_empty;
  logic [$clog2(DEPTH):0] w_unused_count;
  req_t                  w_req_in;
  req_t                  w_head;
  logic                  w_access;
  logic                  w_err;
  logic [WORDS_LOG2-1:0] w_idx;
  logic                  w_wr_en;
  logic                  w_rd_en;

  assign w_req_in = '{store: req_store, addr: req_addr, wdata: req_wdata, be: req_be};

  dmem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (req_valid),
    .i_data  (w_req_in),
    .i_pop   (w_access),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_unused_count)
  );

  assign req_ready = !w_full;

  // The head is popped and executed during the single ACCESS cycle.
  assign w_access = (r_state == ST_ACCESS);
  assign w_err    = addr_err(w_head.addr, WORDS_LOG2);
  assign w_idx    = w_head.addr[WORDS_LOG2+1:2];
  assign w_wr_en  = w_access && w_head.store && !w_err;
  assign w_rd_en  = w_access && !w_head.store && !w_err;

  // Array with per-byte write enables and registered read port; not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_head.be[i]) r_mem[w_idx][8*i +: 8] <= w_head.wdata[8*i +: 8];
      end
    end
    if (w_rd_en) r_ram_q <= r_mem[w_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rsp_err   <= 1'b0;
      r_rsp_store <= 1'b0;
      r_rsp_rd_ok <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          r_state     <= ST_RESP;
          r_rsp_err   <= w_err;
          r_rsp_store <= w_head.store;
          r_rsp_rd_ok <= w_rd_en;
        end
        ST_RESP: begin
          if (rsp_ready) r_state <= w_empty ? ST_IDLE : ST_ACCESS;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_err   = r_rsp_err;
  assign rsp_store = r_rsp_store;
  // Only successful loads expose array data; stores and errors return zero.
  assign rsp_rdata = r_rsp_rd_ok ? r_ram_q : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_store;

  dmem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_store (req_store),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_store (rsp_store)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          store;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] mdl[int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour: memory is a word-indexed map, the valid region is
  // the first 2**18 bytes, and every accepted request yields one response.
  function automatic void model_accept(bit st, logic [31:0] a, logic [31:0] wd, logic [3:0] be);
    exp_t        r;
    logic [31:0] v;
    int          w;
    r.store = st;
    r.err   = (a >= 32'h0004_0000) || (a % 4 != 0);
    r.rdata = 32'd0;
    if (!r.err) begin
      w = int'(a / 4);
      if (st) begin
        v = mdl.exists(w) ? mdl[w] : 32'hxxxx_xxxx;
        for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = wd[8*i +: 8];
        mdl[w] = v;
      end else begin
        r.rdata = mdl[w];
      end
    end
    expq.push_back(r);
  endfunction

  // One clock: records handshakes seen before the edge, then scores them.
  task automatic step(output bit acc);
    bit          hs;
    bit          s_st;
    logic [31:0] s_a, s_wd, s_rd;
    logic [3:0]  s_be;
    bit          s_e, s_s;
    exp_t        e;
    acc  = req_valid && req_ready;
    hs   = rsp_valid && rsp_ready;
    s_st = req_store; s_a = req_addr; s_wd = req_wdata; s_be = req_be;
    s_rd = rsp_rdata; s_e = rsp_err;  s_s = rsp_store;
    tick();
    if (hs) begin
      chk("rsp_expected", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("q_rdata", s_rd, e.rdata);
        chk("q_err",   32'(s_e), 32'(e.err));
        chk("q_store", 32'(s_s), 32'(e.store));
      end
    end
    if (acc) model_accept(s_st, s_a, s_wd, s_be);
  endtask

  task automatic issue(input bit st, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    bit acc;
    acc = 0;
    req_valid = 1'b1; req_store = st; req_addr = a; req_wdata = wd; req_be = be;
    for (int i = 0; i < 100 && !acc; i++) step(acc);
    chk("issue_accept", 32'(acc), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 300 && expq.size() != 0; i++) step(acc);
    chk("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  // Directed helpers (no model): present until ready, accept on next edge.
  task automatic send_req(input bit st, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    req_valid = 1'b1; req_store = st; req_addr = a; req_wdata = wd; req_be = be;
    for (int i = 0; i < 20 && !req_ready; i++) tick();
    chk("send_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 20 && !rsp_valid; i++) tick();
    chk("rsp_arrives", 32'(rsp_valid), 32'd1);
  endtask

  task automatic rsp_hs();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin : main
    bit          acc;
    bit          saw;
    logic [31:0] p_rd;
    logic        p_err, p_st;
    logic [31:0] wv;

    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   32'(rsp_err), 32'd0);
    chk("rst_rsp_store", 32'(rsp_store), 32'd0);

    // Store then load, with latency check on the load
    send_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
    wait_rsp();
    chk("st_err",   32'(rsp_err), 32'd0);
    chk("st_rdata", rsp_rdata, 32'd0);
    chk("st_store", 32'(rsp_store), 32'd1);
    rsp_hs();
    send_req(1'b0, 32'h0000_0010, 32'h0, 4'b0000);
    chk("lat_n0", 32'(rsp_valid), 32'd0);
    tick();
    chk("lat_n1", 32'(rsp_valid), 32'd0);
    tick();
    chk("lat_n2", 32'(rsp_valid), 32'd1);
    chk("ld_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("ld_err",   32'(rsp_err), 32'd0);
    chk("ld_store", 32'(rsp_store), 32'd0);
    rsp_hs();

    // Byte lanes
    send_req(1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101);
    wait_rsp(); rsp_hs();
    send_req(1'b0, 32'h0000_0010, 32'h0, 4'b0000);
    wait_rsp();
    chk("lane_rdata", rsp_rdata, 32'hDE22_BE44);
    rsp_hs();

    // Errors
    send_req(1'b0, 32'h0004_0000, 32'h0, 4'b0000);
    wait_rsp();
    chk("err_oor_err",   32'(rsp_err), 32'd1);
    chk("err_oor_rdata", rsp_rdata, 32'd0);
    rsp_hs();
    send_req(1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 4'b1111);
    wait_rsp();
    chk("err_mis_err",   32'(rsp_err), 32'd1);
    chk("err_mis_store", 32'(rsp_store), 32'd1);
    rsp_hs();
    send_req(1'b0, 32'h0000_0010, 32'h0, 4'b0000);
    wait_rsp();
    chk("err_unchanged", rsp_rdata, 32'hDE22_BE44);
    chk("err_ok_err",    32'(rsp_err), 32'd0);
    rsp_hs();
    send_req(1'b0, 32'h0003_FFFC, 32'h0, 4'b0000);
    wait_rsp();
    chk("top_word_err", 32'(rsp_err), 32'd0);
    rsp_hs();

    // Reset mid-stream: three loads, reset while the second is in RESP
    req_valid = 1'b1; req_store = 1'b0; req_addr = 32'h10; req_be = 4'b0;
    tick(); tick(); tick();
    req_valid = 1'b0;
    chk("rs_first_valid", 32'(rsp_valid), 32'd1);
    chk("rs_first_rdata", rsp_rdata, 32'hDE22_BE44);
    rsp_hs();
    tick();
    chk("rs_second_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rs_async_valid", 32'(rsp_valid), 32'd0);
    chk("rs_async_rdata", rsp_rdata, 32'd0);
    chk("rs_async_err",   32'(rsp_err), 32'd0);
    chk("rs_async_store", 32'(rsp_store), 32'd0);
    chk("rs_async_ready", 32'(req_ready), 32'd1);
    tick(); tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); saw |= rsp_valid; end
    chk("rs_no_stale", 32'(saw), 32'd0);
    rsp_ready = 1'b0;
    send_req(1'b0, 32'h0000_0010, 32'h0, 4'b0000);
    wait_rsp();
    chk("rs_new_rdata", rsp_rdata, 32'hDE22_BE44);
    chk("rs_new_err",   32'(rsp_err), 32'd0);
    rsp_hs();

    // Model-checked region: initialise 8 words at 0x100
    rsp_ready = 1'b1;
    for (int w = 0; w < 8; w++) issue(1'b1, 32'h100 + 32'(4*w), $urandom, 4'b1111);
    drain();

    // Backpressure: 5 accepted, 6th held off, payload stable while stalled
    rsp_ready = 1'b0;
    issue(1'b0, 32'h100, 32'h0, 4'b0000);
    issue(1'b1, 32'h104, $urandom, 4'b0110);
    issue(1'b0, 32'h104, 32'h0, 4'b0000);
    issue(1'b1, 32'h108, $urandom, 4'b1001);
    issue(1'b0, 32'h100, 32'h0, 4'b0000);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    p_rd = rsp_rdata; p_err = rsp_err; p_st = rsp_store;
    req_valid = 1'b1; req_store = 1'b0; req_addr = 32'h108; req_be = 4'b0;
    for (int i = 0; i < 4; i++) begin
      step(acc);
      chk("bp_no_accept", 32'(acc), 32'd0);
    end
    chk("bp_stable_valid", 32'(rsp_valid), 32'd1);
    chk("bp_stable_rdata", rsp_rdata, p_rd);
    chk("bp_stable_err",   32'(rsp_err), 32'(p_err));
    chk("bp_stable_store", 32'(rsp_store), 32'(p_st));
    rsp_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 50 && !acc; i++) step(acc);
    chk("bp_sixth_accept", 32'(acc), 32'd1);
    drain();

    // Randomised traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_store = $urandom_range(0, 1);
      wv = 32'h100 + 32'(4 * $urandom_range(0, 7));
      case ($urandom_range(0, 19))
        0:       req_addr = wv + 32'($urandom_range(1, 3));
        1:       req_addr = 32'h0004_0000 | ($urandom & 32'hFFFF_FFFC);
        default: req_addr = wv;
      endcase
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      step(acc);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for data loads and stores issued by the execute stage. Accepts byte-addressed requests over a valid/ready handshake, buffers them in a small in-order queue, performs the access on an internal 64K×32 word array with per-byte write enables, and returns exactly one response per request, in order. It is the target end of the execute stage's load/store path and replaces the direct, unhandshaked memory hookup.

## Interface

Parameters:
- `DEPTH`, 4: request queue entries; power of two, ≥2.
- `WORDS_LOG2`, 16: log2 of array size in 32-bit words.

Ports:
- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  queue can accept.
- `req_store`  in  1  0 = load, 1 = store.
- `req_addr`  in  32  byte address, computed as base+offset by the initiator.
- `req_wdata`  in  32  store data, lane-aligned.
- `req_be`  in  4  byte enables for stores; ignored for loads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  initiator accepts response.
- `rsp_rdata`  out  32  load data; 0 for stores and errors.
- `rsp_err`  out  1  address out of range or misaligned.
- `rsp_store`  out  1  echo of `req_store` for the response.

## Operation

- Accept: a request is accepted on a rising edge with `req_valid && req_ready`. `req_ready = !full`; a pop in the same cycle does not open a slot when full.
- Error check: a request is in error when `req_addr[31:WORDS_LOG2+2] != 0`, or when `req_addr[1:0] != 0`. An errored request never touches the array. Its response has `rsp_err=1` and `rsp_rdata=0`.
- Word index: `req_addr[WORDS_LOG2+1:2]`.
- FSM states, encoded in the package:
  - IDLE: queue empty. Moves to ACCESS when the queue is non-empty.
  - ACCESS: pops the head. A store writes the enabled lanes; a load issues a synchronous read. Always moves to RESP.
  - RESP: holds `rsp_valid` and all `rsp_*` stable until `rsp_ready`. On handshake, goes to ACCESS if the queue is non-empty, otherwise to IDLE.
- Ordering: responses are strictly in acceptance order. A load following a store to the same word returns the post-store value; this holds naturally because there is one access at a time.
- Store lanes: `be[i]` writes bits `[8i+7:8i]`. `be=0000` is a legal no-op write and still produces a response.
- Array contents are not initialised and not cleared by `rst`.

## Timing

- Reset values: `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `rsp_store=0`, FSM=IDLE, queue empty.
- Latency: a request accepted at edge N, with the queue previously empty, produces `rsp_valid=1` after edge N+2. Read data is registered out of the array at edge N+2.
- Throughput: one request per 2 cycles when `rsp_ready` is held high.
- Backpressure: while `rsp_ready=0`, the queue keeps filling up to `DEPTH`. Then `req_ready=0`.
- Simultaneous push and pop on a non-full queue: both take effect and the count is unchanged.
- Reset asserted mid-operation: the queue is flushed and any in-flight access is abandoned. A store in ACCESS on the same edge as reset assertion may or may not commit; tests must not depend on it. No response is issued for flushed requests.
- Occupancy counter is `$clog2(DEPTH)+1` bits. Pointers wrap modulo `DEPTH`.

## Structure

- Shared package/header `dmem_pkg`: FSM state encoding, request record layout (`store`, `addr`, `wdata`, `be`; 69 bits), and `WORDS_LOG2` default.
- Sub-module `dmem_req_fifo`: a parameterised synchronous FIFO with `full`/`empty`/`count`, holding request records.
- Top level holds the FSM, the error check, the array (inferred single-port RAM with byte-write enables), and the response registers.

## Test plan

- Reset then store/load: store addr `0x0000_0010`, data `0xDEAD_BEEF`, be `1111`, then load same address. Store response is `err=0`, `rdata=0`. Load response is `0xDEAD_BEEF`, arriving 2 cycles after its acceptance when the queue was empty.
- Byte lanes: after the above, store `0x1122_3344` with be `0101` to `0x10`, then load. Load returns `0xDE22_BE44`.
- Errors: load at `0x0004_0000` → `err=1`, `rdata=0`. Store at `0x0000_0012` → `err=1`, and a follow-up load of `0x10` is unchanged.
- Backpressure: hold `rsp_ready=0` and issue 6 requests back-to-back. `req_ready` drops after 4 accepts (DEPTH=4) plus 1 in RESP. Releasing `rsp_ready` drains all responses in order, with payloads unchanged while stalled.
- Reset mid-stream: queue 3 loads, assert `rst` while the second is in RESP. All outputs return to reset values immediately, no stale responses appear afterwards, and a new request completes normally.
